// File: rtl/control_sequencer_if.sv
// Signal bundle between control_sequencer (slave) and its datapath/environment (master).
interface control_sequencer_if #(
  parameter int OPW  = 3,
  parameter int CNTW = 8
);
  logic [OPW-1:0]  ir;
  logic            a_not_zero;
  logic            mem_ack;
  logic            io_ready;
  logic            step;
  logic [2:0]      state;
  logic            mem_req;
  logic            ir_load;
  logic            pc_inc;
  logic            pc_load;
  logic            a_dec;
  logic            in_en;
  logic            out_en;
  logic            halted;
  logic            err;
  logic [CNTW-1:0] retired;

  modport master (
    output ir, a_not_zero, mem_ack, io_ready, step,
    input  state, mem_req, ir_load, pc_inc, pc_load, a_dec, in_en, out_en,
           halted, err, retired
  );

  modport slave (
    input  ir, a_not_zero, mem_ack, io_ready, step,
    output state, mem_req, ir_load, pc_inc, pc_load, a_dec, in_en, out_en,
           halted, err, retired
  );
endinterface

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control sequencer for a small accumulator machine.
// Optional single-step parking after each completed instruction: define STEP_MODE_EN.
//
// state   | meaning
// FETCH   | request instruction, wait for mem_ack
// DECODE  | latch opcode, branch
// EXEC    | one-cycle DEC/JNZ
// WAIT_IO | IN/OUT transfer until io_ready
// PAUSE   | parked after completion until step (STEP_MODE_EN only)
// HALT    | absorbing until reset
module control_sequencer #(
  parameter int OPW  = 3,
  parameter int CNTW = 8
) (
  input logic               clk,
  input logic               rst,
  control_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    FETCH   = 3'b000,
    DECODE  = 3'b001,
    EXEC    = 3'b010,
    WAIT_IO = 3'b011,
    PAUSE   = 3'b100,
    HALT    = 3'b111
  } state_e;

  localparam logic [OPW-1:0] OP_IN  = OPW'(3);
  localparam logic [OPW-1:0] OP_OUT = OPW'(4);
  localparam logic [OPW-1:0] OP_DEC = OPW'(5);
  localparam logic [OPW-1:0] OP_JNZ = OPW'(6);

`ifdef STEP_MODE_EN
  localparam state_e DONE_ST = PAUSE;
`else
  localparam state_e DONE_ST = FETCH;
  logic unused_step;
  assign unused_step = bus.step;
`endif

  state_e          state_q;
  logic [OPW-1:0]  op_q;
  logic [CNTW-1:0] retired_q;
  logic            err_q;
  logic            illegal_ir;

  // Opcodes above 7 only exist when the opcode field is wider than 3 bits.
  generate
    if (OPW > 3) begin : g_wide_op
      assign illegal_ir = |bus.ir[OPW-1:3];
    end else begin : g_narrow_op
      assign illegal_ir = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      op_q      <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.mem_ack) state_q <= DECODE;
        end
        DECODE: begin
          op_q <= bus.ir;
          if (illegal_ir) begin
            err_q   <= 1'b1;
            state_q <= HALT;
          end else begin
            case (bus.ir[2:0])
              3'd3, 3'd4: state_q <= WAIT_IO;
              3'd5, 3'd6: state_q <= EXEC;
              3'd7: begin
                state_q   <= HALT;
                retired_q <= retired_q + CNTW'(1);
              end
              default: begin
                state_q   <= FETCH;
                retired_q <= retired_q + CNTW'(1);
              end
            endcase
          end
        end
        EXEC: begin
          state_q   <= DONE_ST;
          retired_q <= retired_q + CNTW'(1);
        end
        WAIT_IO: begin
          if (bus.io_ready) begin
            state_q   <= DONE_ST;
            retired_q <= retired_q + CNTW'(1);
          end
        end
        PAUSE: begin
`ifdef STEP_MODE_EN
          if (bus.step) state_q <= FETCH;
`else
          state_q <= FETCH;
`endif
        end
        HALT:    state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Fetch strobes are masked during reset so a held mem_ack cannot leak through.
  always_comb begin
    bus.mem_req = 1'b0;
    bus.ir_load = 1'b0;
    bus.pc_inc  = 1'b0;
    bus.pc_load = 1'b0;
    bus.a_dec   = 1'b0;
    bus.in_en   = 1'b0;
    bus.out_en  = 1'b0;
    bus.halted  = 1'b0;
    case (state_q)
      FETCH: begin
        bus.mem_req = 1'b1;
        bus.ir_load = bus.mem_ack & ~rst;
        bus.pc_inc  = bus.mem_ack & ~rst;
      end
      EXEC: begin
        bus.a_dec   = (op_q == OP_DEC);
        bus.pc_load = (op_q == OP_JNZ) & bus.a_not_zero;
      end
      WAIT_IO: begin
        bus.in_en  = (op_q == OP_IN);
        bus.out_en = (op_q == OP_OUT);
      end
      HALT:    bus.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.state   = state_q;
  assign bus.err     = err_q;
  assign bus.retired = retired_q;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OPW, default 3: opcode width in bits; SHALL be >= 3.
REQ-002 Parameter CNTW, default 8: width of the retired-instruction counter.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 ir  input  OPW  current instruction opcode; valid from the DECODE cycle on.
REQ-006 a_not_zero  input  1  accumulator non-zero flag, sampled in EXEC.
REQ-007 mem_ack  input  1  instruction-fetch acknowledge.
REQ-008 io_ready  input  1  IN/OUT transfer-complete strobe.
REQ-009 step  input  1  single-step release pulse; used only when STEP_MODE_EN is defined.
REQ-010 state  output  3  current state code.
REQ-011 mem_req, ir_load, pc_inc, pc_load, a_dec, in_en, out_en  output  1 each  datapath controls.
REQ-012 halted  output  1  high in HALT.
REQ-013 err  output  1  sticky flag: an illegal opcode was decoded.
REQ-014 retired  output  CNTW  count of completed instructions.

Function
REQ-015 State codes SHALL be FETCH=000, DECODE=001, EXEC=010, WAIT_IO=011, PAUSE=100, HALT=111; state is a register, and outputs are decoded from state, op_q and inputs.
REQ-016 FETCH behaviour:
- mem_req=1 while in FETCH.
- On mem_ack=1: ir_load=1 and pc_inc=1 for that cycle only, then go to DECODE.
- With mem_ack=0: remain in FETCH.
REQ-017 DECODE SHALL latch ir into op_q and branch on its value:
- 0..2 (NOP): go to FETCH and count as retired.
- 3 (IN) or 4 (OUT): go to WAIT_IO.
- 5 (DEC) or 6 (JNZ): go to EXEC.
- 7: go to HALT and count as retired.
- Above 7 (possible only when OPW>3): set err, go to HALT, do not count.
REQ-018 EXEC SHALL last exactly one cycle:
- DEC: a_dec=1.
- JNZ: pc_load=a_not_zero.
- Then retire and go to the completion target.
REQ-019 WAIT_IO: in_en=1 (IN) or out_en=1 (OUT) while in the state; hold indefinitely while io_ready=0; on io_ready=1, retire and go to the completion target in the same cycle.
REQ-020 The completion target SHALL be FETCH, or PAUSE when STEP_MODE_EN is defined.
REQ-021 HALT SHALL be absorbing until reset; halted=1, all other controls 0; mem_ack, io_ready and step are ignored.
REQ-022 retired SHALL increment by 1 per retirement and wrap from 2^CNTW-1 to 0.
REQ-023 Minimum latency per NOP instruction is 2 cycles (FETCH with mem_ack=1, then DECODE); DEC/JNZ take 3; IN/OUT take 3 plus io_ready wait cycles.
REQ-024 Any control output not stated as active for a state SHALL be 0 in that state.

Reset
REQ-025 rst=1 SHALL immediately force state=FETCH, op_q=0, retired=0 and err=0, regardless of the clock, including mid-WAIT_IO and in HALT.
REQ-026 Output values while rst=1: mem_req=1; all other control outputs, halted and err 0. The first mem_ack is honoured on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro STEP_MODE_EN:
- Defined: the PAUSE state exists; completion enters PAUSE with all controls 0; step=1 moves PAUSE to FETCH on the next edge. step in any other state is ignored.
- Undefined: PAUSE is unreachable, the step port is ignored, and code 100 is never output.

Verification
REQ-028 Reset, then mem_ack=1 with ir=0 -> state sequence FETCH, DECODE, FETCH; ir_load and pc_inc pulse once; retired=1.
REQ-029 ir=6, a_not_zero=1 -> pc_load=1 for exactly one EXEC cycle; with a_not_zero=0, pc_load stays 0; retired increments in both cases.
REQ-030 ir=3, io_ready held low 5 cycles then pulsed -> in_en=1 for 6 cycles, then FETCH.
REQ-031 CNTW=2, run 5 NOPs -> retired goes 1,2,3,0,1. Separately, OPW=4 with ir=9 -> HALT, err=1, retired unchanged.
REQ-032 Assert rst asynchronously mid-WAIT_IO -> state=FETCH and retired=0 with no clock edge. Separately, with STEP_MODE_EN defined, a DEC instruction parks in PAUSE until step=1.
